// File: rtl/snn_pkg.sv
// Shared AER types and helpers for the spiking-neuron event path.
// Default widths match the 16-neuron, 8-bit timestep configuration.
package snn_pkg;

    localparam int AER_ADDR_WIDTH = 4;
    localparam int AER_TS_WIDTH   = 8;

    typedef struct packed {
        logic [AER_ADDR_WIDTH-1:0] addr;
        logic [AER_TS_WIDTH-1:0]   ts;
    } aer_event_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spike_aer_arbiter_if.sv
// AER output stream: valid/ready handshake with address and timestep.
// master drives the event, slave accepts it.
interface spike_aer_arbiter_if
    import snn_pkg::*;
#(
    parameter int ADDR_WIDTH = AER_ADDR_WIDTH,
    parameter int TS_WIDTH   = AER_TS_WIDTH
);

    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TS_WIDTH-1:0]   ts;

    modport master (
        output valid,
        output addr,
        output ts,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  ts,
        output ready
    );

endinterface

// File: rtl/aer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Head reads as zero while empty so the stream is clean after reset.
module aer_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = count != '0;
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && valid;
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Round-robin AER arbiter: latches neuron spikes, grants one per cycle into a FIFO.
// Define SPIKE_AER_TS_EN to keep a timestep counter and stamp each event.
module spike_aer_arbiter
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_WIDTH  = AER_ADDR_WIDTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_WIDTH    = AER_TS_WIDTH,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_NEURONS-1:0]        in_spike,
    input  logic                          ts_tick,
    spike_aer_arbiter_if.master           aer,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DROP_WIDTH-1:0]         drop_cnt,
    output logic                          busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = DROP_WIDTH + 9;
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;
`ifdef SPIKE_AER_TS_EN
    localparam int EW = ADDR_WIDTH + TS_WIDTH;
`else
    localparam int EW = ADDR_WIDTH;
`endif

    logic [NUM_NEURONS-1:0] pending;
    logic [NUM_NEURONS-1:0] pending_d;
    logic [NUM_NEURONS-1:0] gmask;
    logic [NUM_NEURONS-1:0] merges;
    logic [ADDR_WIDTH-1:0]  rr_ptr;
    logic [ADDR_WIDTH-1:0]  gnt_idx;
    logic                   gnt_vld;
    logic                   fifo_full;
    logic                   fifo_valid;
    logic [SW-1:0]          drop_sum;
    logic [DROP_WIDTH-1:0]  drop_d;
    logic [EW-1:0]          push_data;
    logic [EW-1:0]          head;

    assign fifo_full = fifo_count == CW'(FIFO_DEPTH);

    // First pending neuron at or after rr_ptr, wrapping; stalls when full.
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_NEURONS) begin
                j = j - NUM_NEURONS;
            end
            if (!gnt_vld && pending[ADDR_WIDTH'(j)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ADDR_WIDTH'(j);
            end
        end
        if (fifo_full) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        gmask = '0;
        if (gnt_vld) begin
            gmask[gnt_idx] = 1'b1;
        end
        merges    = in_spike & pending & ~gmask;
        pending_d = (pending & ~gmask) | in_spike;
        drop_sum  = SW'(drop_cnt) + SW'($countones(merges));
        drop_d    = (drop_sum > SW'(DROP_MAX)) ? DROP_MAX
                                               : drop_sum[DROP_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= pending_d;
            drop_cnt <= drop_d;
            if (gnt_vld) begin
                rr_ptr <= ADDR_WIDTH'(rr_next(int'(gnt_idx), NUM_NEURONS));
            end
        end
    end

`ifdef SPIKE_AER_TS_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else if (ts_tick) begin
            ts <= ts + 1'b1;
        end
    end

    assign push_data = {gnt_idx, ts};
    assign aer.addr  = head[EW-1 -: ADDR_WIDTH];
    assign aer.ts    = head[TS_WIDTH-1:0];
`else
    logic unused_ts_tick;

    assign unused_ts_tick = ts_tick;
    assign push_data      = gnt_idx;
    assign aer.addr       = head;
    assign aer.ts         = TS_WIDTH'(0);
`endif

    aer_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_vld),
        .din   (push_data),
        .pop   (aer.ready),
        .dout  (head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign aer.valid = fifo_valid;
    assign busy      = (|pending) | (fifo_count != '0);

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Directed bench for spike_aer_arbiter with an in-order event scoreboard.
// Expected stamps follow SPIKE_AER_TS_EN the same way the design does.
module tb_spike_aer_arbiter;
    import snn_pkg::*;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int TW = 8;
    localparam int DW = 8;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_spike;
    logic          ts_tick;
    logic [3:0]    fifo_count;
    logic [DW-1:0] drop_cnt;
    logic          busy;

    spike_aer_arbiter_if #(.ADDR_WIDTH(AW), .TS_WIDTH(TW)) aer ();

    spike_aer_arbiter #(
        .NUM_NEURONS (N),
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (FD),
        .TS_WIDTH    (TW),
        .DROP_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_spike   (in_spike),
        .ts_tick    (ts_tick),
        .aer        (aer.master),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_fail = 0;
    int         n_checks = 0;
    aer_event_t q[$];
    aer_event_t mon_e;
    logic [TW-1:0] ts_model;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] stamp();
`ifdef SPIKE_AER_TS_EN
        return ts_model;
`else
        return '0;
`endif
    endfunction

    task automatic expect_ev(input int a);
        aer_event_t e;
        e.addr = AW'(a);
        e.ts   = stamp();
        q.push_back(e);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        in_spike = m;
        tick();
        in_spike = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        aer.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        ts_model = '0;
        q.delete();
    endtask

    task automatic drain(input int budget);
        aer.ready = 1'b1;
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            tick();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        tick();
        tick();
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic ts_ticks(input int n);
        ts_tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            ts_model++;
        end
        ts_tick = 1'b0;
    endtask

    task automatic fill_high(input int a0, input int a1, input int a2,
                             input int a3, input int a4, input int a5,
                             input int a6, input int a7);
        aer.ready = 1'b0;
        expect_ev(a0); expect_ev(a1); expect_ev(a2); expect_ev(a3);
        expect_ev(a4); expect_ev(a5); expect_ev(a6); expect_ev(a7);
        pulse(16'hFF00);
        repeat (10) tick();
        chk("fill_full", 32'(fifo_count), 32'd8);
    endtask

    // The transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && aer.valid === 1'b1 && aer.ready === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_unexpected: got addr %0h want none",
                       aer.addr);
            end else begin
                mon_e = q.pop_front();
                chk("sb_addr", 32'(aer.addr), 32'(mon_e.addr));
                chk("sb_ts", 32'(aer.ts), 32'(mon_e.ts));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_spike  = '0;
        ts_tick   = 1'b0;
        aer.ready = 1'b0;
        ts_model  = '0;
        tick();
        tick();
        chk("rst_valid", 32'(aer.valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(aer.addr), 32'd0);
        chk("rst_ts", 32'(aer.ts), 32'd0);
        rst = 1'b0;

        // single spike latency
        expect_ev(0);
        pulse(16'h0001);
        chk("s1_t1_valid", 32'(aer.valid), 32'd0);
        chk("s1_t1_busy", 32'(busy), 32'd1);
        tick();
        chk("s1_t2_valid", 32'(aer.valid), 32'd1);
        chk("s1_t2_addr", 32'(aer.addr), 32'd0);
        chk("s1_t2_count", 32'(fifo_count), 32'd1);
        aer.ready = 1'b1;
        tick();
        chk("s1_pop_count", 32'(fifo_count), 32'd0);
        chk("s1_pop_busy", 32'(busy), 32'd0);

        // all neurons at once: one grant per cycle, in order
        do_reset();
        aer.ready = 1'b1;
        for (int i = 0; i < N; i++) expect_ev(i);
        pulse('1);
        repeat (17) tick();
        chk("s2_sb_empty", 32'(q.size()), 32'd0);
        chk("s2_drop", 32'(drop_cnt), 32'd0);
        chk("s2_busy", 32'(busy), 32'd0);

        // backpressure: fifo fills, head holds, 11 and 12 wait
        aer.ready = 1'b0;
        for (int i = 3; i <= 12; i++) expect_ev(i);
        pulse(16'h1FF8);
        repeat (10) tick();
        chk("s3_full", 32'(fifo_count), 32'd8);
        chk("s3_head", 32'(aer.addr), 32'd3);
        chk("s3_busy", 32'(busy), 32'd1);
        tick();
        chk("s3_hold_addr", 32'(aer.addr), 32'd3);
        chk("s3_hold_count", 32'(fifo_count), 32'd8);
        drain(40);
        chk("s3_drop", 32'(drop_cnt), 32'd0);

        // merge while full: rr_ptr is 13 here
        fill_high(13, 14, 15, 8, 9, 10, 11, 12);
        in_spike = 16'h0020;
        tick();
        tick();
        in_spike = '0;
        chk("s4_drop1", 32'(drop_cnt), 32'd1);
        expect_ev(5);
        drain(40);
        chk("s4_drop1_hold", 32'(drop_cnt), 32'd1);

        // two merges in one cycle
        fill_high(8, 9, 10, 11, 12, 13, 14, 15);
        in_spike = 16'h0060;
        tick();
        tick();
        in_spike = '0;
        chk("s4_drop3", 32'(drop_cnt), 32'd3);
        expect_ev(5);
        expect_ev(6);
        drain(40);

        // saturation
        fill_high(8, 9, 10, 11, 12, 13, 14, 15);
        in_spike = 16'h0020;
        repeat (300) tick();
        in_spike = '0;
        chk("s4_sat", 32'(drop_cnt), 32'd255);
        tick();
        chk("s4_sat_hold", 32'(drop_cnt), 32'd255);
        expect_ev(5);
        drain(40);
        chk("s4_sat_after", 32'(drop_cnt), 32'd255);

        // timestep stamping
        ts_ticks(3);
        expect_ev(7);
        pulse(16'h0080);
        drain(10);
        expect_ev(9);
        pulse(16'h0200);
        ts_tick = 1'b1;
        tick();
        ts_tick = 1'b0;
        ts_model++;
        drain(10);
        ts_ticks(255 - int'(ts_model));
        expect_ev(1);
        pulse(16'h0002);
        drain(10);
        ts_ticks(1);
        expect_ev(2);
        pulse(16'h0004);
        drain(10);

        // reset with 4 queued and 2 pending
        aer.ready = 1'b0;
        pulse(16'h003F);
        repeat (4) tick();
        chk("s6_queued", 32'(fifo_count), 32'd4);
        chk("s6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        in_spike = 16'h0100;
        tick();
        rst = 1'b0;
        in_spike = '0;
        ts_model = '0;
        chk("s6_valid", 32'(aer.valid), 32'd0);
        chk("s6_count", 32'(fifo_count), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_drop", 32'(drop_cnt), 32'd0);
        aer.ready = 1'b1;
        repeat (10) tick();
        chk("s6_stale_count", 32'(fifo_count), 32'd0);
        chk("s6_stale_busy", 32'(busy), 32'd0);
        expect_ev(4);
        pulse(16'h0010);
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
